// File: rtl/retire_trace_q.sv
// rtl/retire_trace_q.sv - retirement event capture into a multi-push trace record FIFO
module retire_trace_q #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_regwrite,
    input  logic [2:0]  ev_wreg,
    input  logic [15:0] ev_wdata,
    input  logic        ev_memread,
    input  logic        ev_memwrite,
    input  logic [15:0] ev_addr,
    input  logic [15:0] ev_mdata_in,
    input  logic [15:0] ev_mdata_out,
    input  logic        ev_halt,
    output logic        stall,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [1:0]  rec_kind,
    output logic [2:0]  rec_reg,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_data,
    output logic [15:0] inst_count,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);
    // Stall when fewer than three free slots remain, so a full cycle always fits.
    localparam logic [AW:0] STALL_LIMIT = (AW+1)'(DEPTH - 3);

    localparam logic [1:0] K_REG   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_HALT  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  rg;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    rec_t          mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   inst_count_q, inst_count_d;

    rec_t          slot [4];
    logic [1:0]    n;
    logic          capture;
    logic          pop;
    rec_t          head;

    assign stall     = (state_q == ST_RUN) && (count_q > STALL_LIMIT);
    assign capture   = (state_q == ST_RUN) && !stall;
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_ready;
    assign head      = rec_valid ? mem_q[rd_ptr_q] : '0;

    assign rec_kind   = head.kind;
    assign rec_reg    = head.rg;
    assign rec_addr   = head.addr;
    assign rec_data   = head.data;
    assign inst_count = inst_count_q;
    assign done       = (state_q == ST_DONE);

    // Pack this cycle's events into consecutive slots in REG, MEM, HALT order.
    always_comb begin
        inst_count_d = inst_count_q;
        for (int i = 0; i < 4; i++) begin
            slot[i] = '0;
        end
        n = 2'd0;
        if (capture && (ev_halt || ev_regwrite || ev_memwrite)) begin
            inst_count_d = inst_count_q + 16'd1;
        end
        if (capture) begin
            if (ev_regwrite) begin
                slot[n] = '{kind: K_REG, rg: ev_wreg, addr: 16'h0000, data: ev_wdata};
                n = n + 2'd1;
            end
            if (ev_memread) begin
                slot[n] = '{kind: K_LOAD, rg: 3'd0, addr: ev_addr, data: ev_mdata_out};
                n = n + 2'd1;
            end else if (ev_memwrite) begin
                slot[n] = '{kind: K_STORE, rg: 3'd0, addr: ev_addr, data: ev_mdata_in};
                n = n + 2'd1;
            end
            if (ev_halt) begin
                slot[n] = '{kind: K_HALT, rg: 3'd0, addr: 16'h0000, data: inst_count_d};
                n = n + 2'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(n);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(n) - (AW+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (capture && ev_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (head.kind == K_HALT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_count_q <= inst_count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < n) begin
                mem_q[wr_ptr_q + AW'(i)] <= slot[i];
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_q.sv
// tb/tb_retire_trace_q.sv - directed scoreboard bench for retire_trace_q
module tb_retire_trace_q;

    logic        clk;
    logic        rst;
    logic        ev_regwrite;
    logic [2:0]  ev_wreg;
    logic [15:0] ev_wdata;
    logic        ev_memread;
    logic        ev_memwrite;
    logic [15:0] ev_addr;
    logic [15:0] ev_mdata_in;
    logic [15:0] ev_mdata_out;
    logic        ev_halt;
    logic        stall;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_kind;
    logic [2:0]  rec_reg;
    logic [15:0] rec_addr;
    logic [15:0] rec_data;
    logic [15:0] inst_count;
    logic        done;

    retire_trace_q #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_regwrite  (ev_regwrite),
        .ev_wreg      (ev_wreg),
        .ev_wdata     (ev_wdata),
        .ev_memread   (ev_memread),
        .ev_memwrite  (ev_memwrite),
        .ev_addr      (ev_addr),
        .ev_mdata_in  (ev_mdata_in),
        .ev_mdata_out (ev_mdata_out),
        .ev_halt      (ev_halt),
        .stall        (stall),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_kind     (rec_kind),
        .rec_reg      (rec_reg),
        .rec_addr     (rec_addr),
        .rec_data     (rec_data),
        .inst_count   (inst_count),
        .done         (done)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  rg;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_rec_t;

    exp_rec_t    sb_q[$];
    logic [15:0] m_inst;
    int          m_state;
    int          tests;
    int          fails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: records expected at the moment events are presented and accepted.
    always @(negedge clk) begin
        exp_rec_t h;
        logic     exp_stall;
        logic     cap;
        if (rst) begin
            sb_q.delete();
            m_inst  = 16'h0000;
            m_state = 0;
        end else begin
            exp_stall = (m_state == 0) && (sb_q.size() > 5);
            cap       = (m_state == 0) && !exp_stall;
            chk("stall", stall, exp_stall);
            chk("rec_valid", rec_valid, sb_q.size() != 0);
            chk("inst_count", inst_count, m_inst);
            chk("done", done, m_state == 2);
            if (sb_q.size() != 0) begin
                chk("rec_kind", rec_kind, sb_q[0].kind);
                chk("rec_reg", rec_reg, sb_q[0].rg);
                chk("rec_addr", rec_addr, sb_q[0].addr);
                chk("rec_data", rec_data, sb_q[0].data);
                if (rec_ready) begin
                    h = sb_q.pop_front();
                    if (h.kind == 2'd3) m_state = 2;
                end
            end
            if (cap) begin
                if (ev_halt || ev_regwrite || ev_memwrite) m_inst = m_inst + 16'd1;
                if (ev_regwrite) sb_q.push_back('{2'd0, ev_wreg, 16'h0000, ev_wdata});
                if (ev_memread) sb_q.push_back('{2'd1, 3'd0, ev_addr, ev_mdata_out});
                else if (ev_memwrite) sb_q.push_back('{2'd2, 3'd0, ev_addr, ev_mdata_in});
                if (ev_halt) begin
                    sb_q.push_back('{2'd3, 3'd0, 16'h0000, m_inst});
                    m_state = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        ev_regwrite  = 1'b0;
        ev_wreg      = 3'd0;
        ev_wdata     = 16'h0000;
        ev_memread   = 1'b0;
        ev_memwrite  = 1'b0;
        ev_addr      = 16'h0000;
        ev_mdata_in  = 16'h0000;
        ev_mdata_out = 16'h0000;
        ev_halt      = 1'b0;
    endtask

    task automatic wait_take();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1'b1);
        cyc();
        clear_ev();
    endtask

    task automatic ev(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                      input logic mr, input logic mw, input logic [15:0] a,
                      input logic [15:0] mdi, input logic [15:0] mdo, input logic h);
        ev_regwrite  = rw;
        ev_wreg      = wr;
        ev_wdata     = wd;
        ev_memread   = mr;
        ev_memwrite  = mw;
        ev_addr      = a;
        ev_mdata_in  = mdi;
        ev_mdata_out = mdo;
        ev_halt      = h;
        wait_take();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 32; i++) begin
            if (!rec_valid) break;
            cyc();
        end
        chk("drain_empty", rec_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] saved;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        rec_ready = 1'b0;
        clear_ev();
        cyc();
        do_reset();

        chk("reset_rec_valid", rec_valid, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_inst", inst_count, 16'h0000);
        chk("reset_fields", {rec_kind, rec_reg, rec_addr, rec_data}, 37'h0);

        ev(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        chk("t1_valid", rec_valid, 1'b1);
        chk("t1_kind", rec_kind, 2'd0);
        chk("t1_reg", rec_reg, 3'd3);
        chk("t1_data", rec_data, 16'h1234);
        chk("t1_inst", inst_count, 16'd1);
        rec_ready = 1'b1;
        cyc();
        chk("t1_popped", rec_valid, 1'b0);

        do_reset();
        rec_ready = 1'b1;
        ev(1'b1, 3'd5, 16'h00AA, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0, 1'b0);
        chk("t2_reg_kind", rec_kind, 2'd0);
        chk("t2_reg_data", rec_data, 16'h00AA);
        cyc();
        chk("t2_st_kind", rec_kind, 2'd2);
        chk("t2_st_addr", rec_addr, 16'h0040);
        chk("t2_st_data", rec_data, 16'hBEEF);
        chk("t2_inst", inst_count, 16'd1);
        cyc();
        chk("t2_empty", rec_valid, 1'b0);

        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ev(1'b1, 3'(i + 1), 16'h1100 + 16'(i), 1'b1, 1'b0, 16'h0200 + 16'(i),
               16'h0, 16'h2200 + 16'(i), 1'b0);
        end
        chk("t3_stall_at_6", stall, 1'b1);
        ev_regwrite  = 1'b1;
        ev_wreg      = 3'd6;
        ev_wdata     = 16'h6666;
        ev_memwrite  = 1'b1;
        ev_addr      = 16'h0300;
        ev_mdata_in  = 16'h3333;
        cyc();
        cyc();
        chk("t3_stall_held", stall, 1'b1);
        rec_ready = 1'b1;
        wait_take();
        wait_empty();

        rec_ready = 1'b0;
        saved = inst_count;
        ev(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h7777, 1'b0);
        chk("t4_kind", rec_kind, 2'd1);
        chk("t4_addr", rec_addr, 16'h0100);
        chk("t4_data", rec_data, 16'h7777);
        chk("t4_inst", inst_count, saved);
        rec_ready = 1'b1;
        cyc();
        wait_empty();

        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        end
        cyc();
        rec_ready = 1'b0;
        ev(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
        chk("t5_halt_kind", rec_kind, 2'd3);
        chk("t5_halt_data", rec_data, 16'h0005);
        ev(1'b1, 3'd2, 16'hDEAD, 1'b0, 1'b1, 16'h0050, 16'h5555, 16'h0, 1'b0);
        chk("t5_ignored_inst", inst_count, 16'h0005);
        chk("t5_ignored_head", rec_kind, 2'd3);
        chk("t5_done_before", done, 1'b0);
        rec_ready = 1'b1;
        cyc();
        chk("t5_done", done, 1'b1);
        chk("t5_empty", rec_valid, 1'b0);
        cyc();
        cyc();
        chk("t5_done_hold", done, 1'b1);

        do_reset();
        rec_ready = 1'b0;
        ev(1'b1, 3'd1, 16'h0101, 1'b0, 1'b1, 16'h0010, 16'h1010, 16'h0, 1'b0);
        ev(1'b1, 3'd2, 16'h0202, 1'b0, 1'b1, 16'h0020, 16'h2020, 16'h0, 1'b0);
        ev(1'b1, 3'd3, 16'h0303, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        chk("t6_buffered", rec_valid, 1'b1);
        rst = 1'b1;
        cyc();
        chk("t6_rst_valid", rec_valid, 1'b0);
        chk("t6_rst_inst", inst_count, 16'h0000);
        chk("t6_rst_done", done, 1'b0);
        rst = 1'b0;
        ev(1'b1, 3'd7, 16'h5A5A, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        chk("t6_fresh_reg", rec_reg, 3'd7);
        chk("t6_fresh_data", rec_data, 16'h5A5A);
        rec_ready = 1'b1;
        cyc();
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/retire_trace_q.md
# retire_trace_q

Hardware retirement-trace producer on the processor's commit side. Each cycle it captures retirement events from the pipeline (register writeback, data-memory load, data-memory store, halt), encodes them as fixed-format records and buffers them in a FIFO. The FIFO drains over a valid/ready port to an off-core trace sink. The block applies backpressure to the pipeline when the buffer cannot accept a full cycle's worth of events.

## Interface
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ev_regwrite  in  1  MEM/WB register write this cycle.
- ev_wreg  in  3  register written.
- ev_wdata  in  16  data written.
- ev_memread  in  1  EX/MEM load this cycle.
- ev_memwrite  in  1  EX/MEM store this cycle; never high together with ev_memread.
- ev_addr  in  16  memory address.
- ev_mdata_in  in  16  store data.
- ev_mdata_out  in  16  load data.
- ev_halt  in  1  halt retired.
- stall  out  1  pipeline must hold all ev_* inputs unchanged.
- rec_valid  out  1  record available.
- rec_ready  in  1  sink accepts the record.
- rec_kind  out  2  0=REG, 1=LOAD, 2=STORE, 3=HALT.
- rec_reg  out  3  register number (REG records); 0 otherwise.
- rec_addr  out  16  address (LOAD/STORE records); 0 otherwise.
- rec_data  out  16  write data, load data or store data; for HALT, the inst_count value.
- inst_count  out  16  retired-instruction counter.
- done  out  1  halt record consumed by the sink.

## Operation
- States:
  - RUN: capture enabled.
  - DRAIN: halt captured; ev_* ignored.
  - DONE: terminal.
- Capture occurs in RUN when stall=0. A cycle's events are pushed in the fixed order REG, LOAD/STORE, HALT. Up to 3 records are pushed per cycle.
- Per-cycle push count n = ev_regwrite + (ev_memread | ev_memwrite) + ev_halt. Entries are written at wr_ptr, wr_ptr+1 and wr_ptr+2, each modulo DEPTH.
- inst_count increments by 1 on a capture cycle when (ev_halt | ev_regwrite | ev_memwrite). It wraps from 0xFFFF to 0x0000.
- HALT record data = inst_count including the halt cycle's own increment.
- Capturing ev_halt moves the state RUN→DRAIN.
- DRAIN→DONE happens when the HALT record pops (rec_valid & rec_ready while rec_kind=3).
- The FIFO is a circular buffer with wr_ptr, rd_ptr and count. count width is log2(DEPTH)+1.
- Pop occurs when rec_valid & rec_ready. rec_valid = (count != 0). rec_* come from the rd_ptr entry.
- Simultaneous push n and pop: count_next = count + n − pop.

## Timing
- Reset values:
  - state = RUN
  - count = 0, wr_ptr = 0, rd_ptr = 0
  - inst_count = 0
  - stall = 0, rec_valid = 0, done = 0
  - rec_kind, rec_reg, rec_addr and rec_data all 0
- stall is combinational from registered count: stall = (state==RUN) & (DEPTH − count < 3).
  - A same-cycle pop is not credited toward freeing space.
  - In DRAIN and DONE, stall = 0.
- Latency: events captured at rising edge N appear as rec_valid=1 in cycle N+1 when the FIFO was empty. There is no bypass.
- rec_* remain stable while rec_valid=1 and rec_ready=0.
- done rises the cycle after the HALT pop and holds until rst.
- rst mid-operation discards all buffered records, returns to RUN and clears inst_count on the next edge.
- A cycle with n=0 and stall=0 pushes nothing. inst_count is unchanged.

## Test plan
- Reset, then ev_regwrite=1, ev_wreg=3, ev_wdata=0x1234 for one cycle.
  - Required: next cycle rec_valid=1, kind=0, reg=3, data=0x1234, inst_count=1.
- Same cycle ev_regwrite (r5, 0x00AA) and ev_memwrite (addr 0x0040, data 0xBEEF), with rec_ready=1.
  - Required: REG record, then STORE record (addr 0x0040, data 0xBEEF) on consecutive cycles.
  - Required: inst_count=1.
- rec_ready=0 with DEPTH=8 and two-event cycles.
  - Required: stall=1 once count=6.
  - Required: the held events are captured exactly once after rec_ready=1 frees space.
  - Required: no record is lost or duplicated.
- ev_memread addr 0x0100, data 0x7777.
  - Required: kind=1, addr=0x0100, data=0x7777.
  - Required: inst_count unchanged.
- ev_halt after 4 counted instructions.
  - Required: HALT record data=0x0005.
  - Required: later ev_* are ignored.
  - Required: done=1 the cycle after the HALT pop.
- Assert rst with 5 records buffered.
  - Required: next cycle rec_valid=0, inst_count=0, state RUN.
  - Required: a fresh event pushes into entry 0.
